theta_round: RTL and testbench

Keccak-f[1600] theta step, multi-cycle. It sits directly upstream of rho_round in the round datapath.
- Accepts a 1600-bit state on a start pulse and computes column parities.
- Applies the theta mix and presents theta_transform with a one-cycle done pulse.
- theta_transform and done feed rho_round's state and start.

---
 rtl/keccak_pkg.sv | 18 +
 rtl/theta_round_rotl.sv | 13 +
 rtl/theta_round.sv | 84 ++++++++
 tb/tb_theta_round.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] constants, lane indexing and round FSM encoding.
package keccak_pkg;

    localparam int unsigned LANE_W    = 64;
    localparam int unsigned NUM_LANES = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PARITY = 2'd1,
        APPLY  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int unsigned idx(input int unsigned x, input int unsigned y);
        return x + 5 * y;
    endfunction

endpackage

// File: rtl/theta_round_rotl.sv
// Lane rotate-left by n bits; bit 63 wraps to bit 0 for n = 1.
module theta_round_rotl
    import keccak_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [5:0]        n,
    output logic [LANE_W-1:0] out
);

    // Right shift by 64 when n = 0 yields zero, so out = a in that case.
    assign out = (a << n) | (a >> (7'd64 - {1'b0, n}));

endmodule

// File: rtl/theta_round.sv
// Keccak-f[1600] theta step: latch state, compute column parities, apply mix.
module theta_round (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1599:0] state,
    output logic [1599:0] theta_transform,
    output logic          done,
    output logic          busy
);
    import keccak_pkg::*;

    state_t                    fsm;
    logic [1599:0]             st_reg;
    logic [LANE_W-1:0]         c      [5];
    logic [LANE_W-1:0]         c_next [5];
    logic [LANE_W-1:0]         rot    [5];
    logic [LANE_W-1:0]         d      [5];
    logic [1599:0]             theta_next;

    always_comb begin
        for (int unsigned x = 0; x < 5; x++) begin
            c_next[x] = '0;
            for (int unsigned y = 0; y < 5; y++) begin
                c_next[x] = c_next[x] ^ st_reg[LANE_W*idx(x, y) +: LANE_W];
            end
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_d
        theta_round_rotl u_rotl (
            .a   (c[(g + 1) % 5]),
            .n   (6'd1),
            .out (rot[g])
        );
        assign d[g] = c[(g + 4) % 5] ^ rot[g];
    end

    always_comb begin
        theta_next = '0;
        for (int unsigned y = 0; y < 5; y++) begin
            for (int unsigned x = 0; x < 5; x++) begin
                theta_next[LANE_W*idx(x, y) +: LANE_W] = st_reg[LANE_W*idx(x, y) +: LANE_W] ^ d[x];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm             <= IDLE;
            st_reg          <= '0;
            c               <= '{default: '0};
            theta_transform <= '0;
            done            <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start) begin
                        st_reg <= state;
                        busy   <= 1'b1;
                        fsm    <= PARITY;
                    end
                end
                PARITY: begin
                    c   <= c_next;
                    fsm <= APPLY;
                end
                APPLY: begin
                    theta_transform <= theta_next;
                    done            <= 1'b1;
                    fsm             <= DONE;
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    fsm  <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_theta_round.sv
// Directed bench for theta_round with hand-computed theta results.
module tb_theta_round;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1599:0] state;
    logic [1599:0] theta_transform;
    logic          done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [1599:0] in_l0, in_l2, in_ones;
    logic [1599:0] exp_l0, exp_l2, exp_ones;
    logic [1599:0] exp_q [3];
    int            pulses;

    theta_round dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .state           (state),
        .theta_transform (theta_transform),
        .done            (done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        int ln;
        ln = 0;
        for (int i = 24; i >= 0; i--) begin
            if (obs[64*i +: 64] !== exp[64*i +: 64]) ln = i;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: lane %0d got %h expected %h", tag, ln, obs[64*ln +: 64], exp[64*ln +: 64]);
        end
    endtask

    // Drives one start pulse and checks the full busy/done timeline.
    task automatic run_job(input string tag, input logic [1599:0] s, input logic [1599:0] exp);
        @(negedge clk);
        state = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        state = '1 ^ s;
        chk_bit({tag, "_busy1"}, busy, 1'b1);
        chk_bit({tag, "_done1"}, done, 1'b0);
        @(negedge clk);
        chk_bit({tag, "_busy2"}, busy, 1'b1);
        chk_bit({tag, "_done2"}, done, 1'b0);
        @(negedge clk);
        chk_bit({tag, "_busy3"}, busy, 1'b1);
        chk_bit({tag, "_done3"}, done, 1'b1);
        chk_state({tag, "_theta"}, theta_transform, exp);
        @(negedge clk);
        chk_bit({tag, "_busy4"}, busy, 1'b0);
        chk_bit({tag, "_done4"}, done, 1'b0);
        chk_state({tag, "_hold"}, theta_transform, exp);
    endtask

    initial begin
        in_l0    = '0;
        in_l0[63:0] = 64'h1;
        in_l2    = '0;
        in_l2[64*2 +: 64] = 64'h8000000000000000;
        in_ones  = '1;

        exp_l0 = '0;
        exp_l2 = '0;
        for (int y = 0; y < 5; y++) begin
            exp_l0[64*(1 + 5*y) +: 64] = 64'h1;
            exp_l0[64*(4 + 5*y) +: 64] = 64'h2;
            exp_l2[64*(1 + 5*y) +: 64] = 64'h1;
            exp_l2[64*(3 + 5*y) +: 64] = 64'h8000000000000000;
        end
        exp_l0[63:0] = 64'h1;
        exp_l2[64*2 +: 64] = 64'h8000000000000000;
        exp_ones = '1;

        rst   = 1'b1;
        start = 1'b0;
        state = '1;
        @(negedge clk);
        @(negedge clk);
        chk_state("reset_theta", theta_transform, '0);
        chk_bit("reset_done", done, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        rst = 1'b0;

        run_job("zero", '0, '0);
        run_job("lane0", in_l0, exp_l0);
        run_job("lane2_wrap", in_l2, exp_l2);
        run_job("ones", in_ones, exp_ones);

        // start held high for 12 edges; only edges 0, 4 and 8 accept.
        exp_q[0] = exp_l0;
        exp_q[1] = exp_l2;
        exp_q[2] = exp_ones;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                chk_bit("held_pulse_timing", (i == 3 + 4*pulses), 1'b1);
                if (pulses < 3) chk_state("held_theta", theta_transform, exp_q[pulses]);
                pulses++;
            end
            if (i < 12) begin
                start = 1'b1;
                case (i)
                    0:       state = in_l0;
                    4:       state = in_l2;
                    8:       state = in_ones;
                    default: state = {25{$urandom(), $urandom()}};
                endcase
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        assert (pulses == 3) else begin
            errors++;
            $error("FAIL held_pulse_count: got %0d expected 3", pulses);
        end
        chk_bit("held_idle", busy, 1'b0);

        // Reset while in APPLY discards the job.
        @(negedge clk);
        state = in_l0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_state("rst_apply_theta", theta_transform, '0);
        chk_bit("rst_apply_done", done, 1'b0);
        chk_bit("rst_apply_busy", busy, 1'b0);
        @(negedge clk);
        chk_bit("rst_apply_nodone", done, 1'b0);
        run_job("after_rst", in_l2, exp_l2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
